axis_to_dvp: RTL

- Converts an AXI4-Stream video stream (tuser = start of frame, tlast = end of line) into DVP-style parallel video: data_out, href, vsync.
- Sits on the display/output side of the image pipeline; counterpart of the DVP capture path.
- Owns free-running line and frame timing, pulls pixels from the stream only during active href, and flags stream/timing mismatches.

---
 rtl/axis_dvp_pkg.sv | 15 +
 rtl/axis_to_dvp_if.sv | 25 ++
 rtl/dvp_timing_gen.sv | 124 ++++++++++++
 rtl/axis_to_dvp.sv | 94 +++++++++
 4 files changed

// File: rtl/axis_dvp_pkg.sv
// Shared types and constants for the AXI4-Stream to DVP output path.
package axis_dvp_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [2:0] {
    WAIT_SOF,
    VSYNC,
    VBACK,
    ACTIVE,
    HBLANK,
    VFRONT
  } dvp_state_t;

endpackage

// File: rtl/axis_to_dvp_if.sv
// Stream input and DVP output bundle of axis_to_dvp; slave is the converter side.
interface axis_to_dvp_if #(
  parameter int DATA_WIDTH = 10
);

  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  s_axis_tuser;
  logic                  s_axis_tlast;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  href;
  logic                  vsync;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast,
    output s_axis_tready, data_out, href, vsync
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast,
    input  s_axis_tready, data_out, href, vsync
  );

endinterface

// File: rtl/dvp_timing_gen.sv
// Free-running DVP line/frame timing: owns the counters and frame FSM and
// publishes per-cycle slot strobes for the stream-side logic.
module dvp_timing_gen
  import axis_dvp_pkg::*;
#(
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480,
  parameter int H_BLANK       = 160,
  parameter int VSYNC_LINES   = 3,
  parameter int V_BACK_LINES  = 17,
  parameter int V_FRONT_LINES = 10
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sofAvail,
  output logic o_waitSof,
  output logic o_vsyncSlot,
  output logic o_active,
  output logic o_firstPixel,
  output logic o_lastPixel,
  output logic o_frameEnd
);

  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(IMG_WIDTH + H_BLANK - 1);
  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(VSYNC_LINES - 1);
  localparam logic [CNT_W-1:0] VB_LAST   = CNT_W'(V_BACK_LINES - 1);
  localparam logic [CNT_W-1:0] VF_LAST   = CNT_W'(V_FRONT_LINES - 1);

  dvp_state_t       r_state, w_stateNext;
  logic [CNT_W-1:0] r_hCnt, w_hCntNext;
  logic [CNT_W-1:0] r_vCnt, w_vCntNext;
  logic             w_lineEnd;

  assign w_lineEnd = (r_hCnt == LINE_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= WAIT_SOF;
      r_hCnt  <= '0;
      r_vCnt  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_hCnt  <= w_hCntNext;
      r_vCnt  <= w_vCntNext;
    end
  end

  // h_cnt runs across ACTIVE and HBLANK so both share one line period
  always_comb begin
    w_stateNext = r_state;
    w_hCntNext  = r_hCnt + 1'b1;
    w_vCntNext  = r_vCnt;
    case (r_state)
      WAIT_SOF: begin
        w_hCntNext = '0;
        w_vCntNext = '0;
        if (i_sofAvail) w_stateNext = VSYNC;
      end
      VSYNC: begin
        if (w_lineEnd) begin
          w_hCntNext = '0;
          if (r_vCnt == VS_LAST) begin
            w_vCntNext  = '0;
            w_stateNext = VBACK;
          end else begin
            w_vCntNext = r_vCnt + 1'b1;
          end
        end
      end
      VBACK: begin
        if (w_lineEnd) begin
          w_hCntNext = '0;
          if (r_vCnt == VB_LAST) begin
            w_vCntNext  = '0;
            w_stateNext = ACTIVE;
          end else begin
            w_vCntNext = r_vCnt + 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (r_hCnt == PIX_LAST) w_stateNext = HBLANK;
      end
      HBLANK: begin
        if (w_lineEnd) begin
          w_hCntNext = '0;
          if (r_vCnt < ROW_LAST) begin
            w_vCntNext  = r_vCnt + 1'b1;
            w_stateNext = ACTIVE;
          end else begin
            w_vCntNext  = '0;
            w_stateNext = VFRONT;
          end
        end
      end
      VFRONT: begin
        if (w_lineEnd) begin
          w_hCntNext = '0;
          if (r_vCnt == VF_LAST) begin
            w_vCntNext  = '0;
            w_stateNext = i_sofAvail ? VSYNC : WAIT_SOF;
          end else begin
            w_vCntNext = r_vCnt + 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = WAIT_SOF;
        w_hCntNext  = '0;
        w_vCntNext  = '0;
      end
    endcase
  end

  assign o_waitSof    = (r_state == WAIT_SOF);
  assign o_vsyncSlot  = (r_state == VSYNC);
  assign o_active     = (r_state == ACTIVE);
  assign o_firstPixel = o_active && (r_hCnt == '0) && (r_vCnt == '0);
  assign o_lastPixel  = o_active && (r_hCnt == PIX_LAST);
  assign o_frameEnd   = (r_state == VFRONT) && w_lineEnd && (r_vCnt == VF_LAST);

endmodule

// File: rtl/axis_to_dvp.sv
// AXI4-Stream video to DVP parallel video: stream handshake, registered pixel
// output and stream/timing mismatch reporting around dvp_timing_gen.
module axis_to_dvp
  import axis_dvp_pkg::*;
#(
  parameter int DATA_WIDTH    = 10,
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480,
  parameter int H_BLANK       = 160,
  parameter int VSYNC_LINES   = 3,
  parameter int V_BACK_LINES  = 17,
  parameter int V_FRONT_LINES = 10
) (
  input  logic         piexl_clk,
  input  logic         reset,
  axis_to_dvp_if.slave bus,
  output logic         err_underflow,
  output logic         err_eol,
  output logic         err_sof
);

  logic w_waitSof, w_vsyncSlot, w_active, w_firstPixel, w_lastPixel, w_frameEnd;
  logic w_sofAvail, w_midSof, w_tready, w_accept, w_vsyncEntry;

  logic [DATA_WIDTH-1:0] r_data;
  logic r_href, r_vsync, r_errUnder, r_errEol, r_errSof, r_abort;

  dvp_timing_gen #(
    .IMG_WIDTH    (IMG_WIDTH),
    .IMG_HEIGHT   (IMG_HEIGHT),
    .H_BLANK      (H_BLANK),
    .VSYNC_LINES  (VSYNC_LINES),
    .V_BACK_LINES (V_BACK_LINES),
    .V_FRONT_LINES(V_FRONT_LINES)
  ) u_timing (
    .i_clk       (piexl_clk),
    .i_reset     (reset),
    .i_sofAvail  (w_sofAvail),
    .o_waitSof   (w_waitSof),
    .o_vsyncSlot (w_vsyncSlot),
    .o_active    (w_active),
    .o_firstPixel(w_firstPixel),
    .o_lastPixel (w_lastPixel),
    .o_frameEnd  (w_frameEnd)
  );

  assign w_sofAvail   = bus.s_axis_tvalid & bus.s_axis_tuser;
  assign w_midSof     = w_active & ~r_abort & w_sofAvail & ~w_firstPixel;
  assign w_vsyncEntry = w_sofAvail & (w_waitSof | w_frameEnd);

  // A mid-frame SOF beat is held back so it can open the next frame
  always_comb begin
    w_tready = 1'b0;
    if (reset) begin
      w_tready = 1'b0;
    end else if (w_waitSof) begin
      w_tready = bus.s_axis_tvalid & ~bus.s_axis_tuser;
    end else if (w_active) begin
      w_tready = ~r_abort & ~w_midSof;
    end
  end

  assign w_accept          = w_active & w_tready & bus.s_axis_tvalid;
  assign bus.s_axis_tready = w_tready;

  always_ff @(posedge piexl_clk) begin
    if (reset) begin
      r_data     <= '0;
      r_href     <= 1'b0;
      r_vsync    <= 1'b0;
      r_errUnder <= 1'b0;
      r_errEol   <= 1'b0;
      r_errSof   <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_data     <= w_accept ? bus.s_axis_tdata : '0;
      r_href     <= w_active;
      r_vsync    <= w_vsyncSlot;
      r_errUnder <= w_active & w_tready & ~bus.s_axis_tvalid;
      r_errEol   <= w_accept & (bus.s_axis_tlast != w_lastPixel);
      r_errSof   <= w_midSof;
      if (w_vsyncEntry) r_abort <= 1'b0;
      else if (w_midSof) r_abort <= 1'b1;
    end
  end

  assign bus.data_out  = r_data;
  assign bus.href      = r_href;
  assign bus.vsync     = r_vsync;
  assign err_underflow = r_errUnder;
  assign err_eol       = r_errEol;
  assign err_sof       = r_errSof;

endmodule
